// File: rtl/port_ingress_if.sv
`default_nettype none
// ============================================================================
// Module   : port_ingress_if
// Brief    : Ingress word stream plus per-port output FIFO write bus.
// Revision : 1.0  initial release
// ============================================================================
interface port_ingress_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sop;
    logic                    in_eop;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [3:0]              fifo_full;
    logic [3:0]              wr_en;
    logic [DATA_WIDTH+1:0]   wr_data;

    // master: traffic source and FIFO side; slave: the classifier
    modport master (
        output in_valid, in_sop, in_eop, in_data, fifo_full,
        input  in_ready, wr_en, wr_data
    );
    modport slave (
        input  in_valid, in_sop, in_eop, in_data, fifo_full,
        output in_ready, wr_en, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/port_ingress.sv
`default_nettype none
// ============================================================================
// Module   : port_ingress
// Brief    : Ingress classifier routing framed packets to one of four output
//            FIFOs by header address; drops unroutable, truncates oversize.
//            Packet statistics built only when PORT_INGRESS_STATS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module port_ingress #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PORT_ADDR0 = 32'hDEAD_0000,
    parameter logic [DATA_WIDTH-1:0] PORT_ADDR1 = 32'hDEAD_0001,
    parameter logic [DATA_WIDTH-1:0] PORT_ADDR2 = 32'hDEAD_0002,
    parameter logic [DATA_WIDTH-1:0] PORT_ADDR3 = 32'hDEAD_0003,
    parameter int                    MAX_WORDS  = 64
) (
    input  wire logic        clk,
    input  wire logic        reset,
    port_ingress_if.slave    bus,
    output logic [15:0]      pkt_fwd_cnt,
    output logic [15:0]      pkt_drop_cnt,
    output logic             err_proto,
    output logic             err_len,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // wcnt holds words already accepted, so the word being accepted is wcnt+1
    localparam logic [15:0] c_last_wcnt = 16'(MAX_WORDS - 1);

    state_t      r_state;
    logic [1:0]  r_cur_port;
    logic [15:0] r_wcnt;
    logic        r_err_proto;
    logic        r_err_len;

    logic [3:0]  w_match;
    logic        w_hit;
    logic [1:0]  w_hit_port;
    logic        w_hdr_fwd;
    logic        w_trunc;
    logic        w_ready;
    logic        w_wr;
    logic [1:0]  w_tgt;
    logic        w_sop_eff;
    logic        w_eop_eff;
    logic        w_accept;

    assign w_match = {bus.in_data == PORT_ADDR3, bus.in_data == PORT_ADDR2,
                      bus.in_data == PORT_ADDR1, bus.in_data == PORT_ADDR0};
    assign w_hit   = |w_match;

    always_comb begin
        w_hit_port = 2'd0;
        if (w_match[0])      w_hit_port = 2'd0;
        else if (w_match[1]) w_hit_port = 2'd1;
        else if (w_match[2]) w_hit_port = 2'd2;
        else if (w_match[3]) w_hit_port = 2'd3;
    end

    assign w_hdr_fwd = (r_state == S_IDLE) && bus.in_sop && w_hit;
    assign w_trunc   = (r_state == S_FWD) && (r_wcnt == c_last_wcnt) && !bus.in_eop;

    always_comb begin
        w_ready   = 1'b1;
        w_wr      = 1'b0;
        w_tgt     = r_cur_port;
        w_sop_eff = 1'b0;
        w_eop_eff = bus.in_eop;
        case (r_state)
            S_IDLE: begin
                if (w_hdr_fwd) begin
                    w_tgt     = w_hit_port;
                    w_ready   = !bus.fifo_full[w_hit_port];
                    w_wr      = 1'b1;
                    w_sop_eff = 1'b1;
                end
            end
            S_FWD: begin
                // a stray sop mid-packet is written with its sop bit cleared
                w_ready   = !bus.fifo_full[r_cur_port];
                w_wr      = 1'b1;
                w_eop_eff = bus.in_eop | w_trunc;
            end
            default: ;
        endcase
    end

    assign w_accept     = bus.in_valid && w_ready;
    assign bus.in_ready = w_ready;
    assign bus.wr_en    = (w_accept && w_wr) ? (4'b0001 << w_tgt) : 4'b0000;
    assign bus.wr_data  = (w_accept && w_wr) ? {w_sop_eff, w_eop_eff, bus.in_data}
                                             : {2'b00, bus.in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur_port  <= 2'd0;
            r_wcnt      <= 16'd0;
            r_err_proto <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_err_proto <= 1'b0;
            r_err_len   <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_hdr_fwd) begin
                            r_cur_port <= w_hit_port;
                            r_wcnt     <= 16'd1;
                            if (!bus.in_eop) r_state <= S_FWD;
                        end else if (bus.in_sop) begin
                            if (!bus.in_eop) r_state <= S_DROP;
                        end else begin
                            r_err_proto <= 1'b1;
                        end
                    end
                    S_FWD: begin
                        r_wcnt      <= r_wcnt + 16'd1;
                        r_err_proto <= bus.in_sop;
                        if (bus.in_eop) begin
                            r_state <= S_IDLE;
                        end else if (w_trunc) begin
                            r_err_len <= 1'b1;
                            r_state   <= S_DROP;
                        end
                    end
                    S_DROP: begin
                        r_err_proto <= bus.in_sop;
                        if (bus.in_eop) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef PORT_INGRESS_STATS_EN
    logic        w_fwd_inc;
    logic        w_drop_inc;
    logic [15:0] r_fwd_cnt;
    logic [15:0] r_drop_cnt;

    assign w_fwd_inc  = w_accept && ((w_hdr_fwd && bus.in_eop) ||
                        ((r_state == S_FWD) && (bus.in_eop || w_trunc)));
    assign w_drop_inc = w_accept && (r_state == S_IDLE) && bus.in_sop && !w_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_cnt  <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_fwd_inc && (r_fwd_cnt != 16'hFFFF))   r_fwd_cnt  <= r_fwd_cnt + 16'd1;
            if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign pkt_fwd_cnt  = r_fwd_cnt;
    assign pkt_drop_cnt = r_drop_cnt;
`else
    assign pkt_fwd_cnt  = 16'h0000;
    assign pkt_drop_cnt = 16'h0000;
`endif

    assign err_proto = r_err_proto;
    assign err_len   = r_err_len;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_port_ingress.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_ingress
// Brief    : Directed vector table, reset sequence and randomized packet
//            traffic checked against a packet-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_port_ingress;

    localparam int c_max   = 4;
    localparam int c_npkt  = 250;
    localparam int c_limit = 60000;

    logic        clk;
    logic        reset;
    logic [15:0] pkt_fwd_cnt;
    logic [15:0] pkt_drop_cnt;
    logic        err_proto;
    logic        err_len;
    logic        busy;

    port_ingress_if #(.DATA_WIDTH(32)) bus ();

    port_ingress #(.DATA_WIDTH(32), .MAX_WORDS(c_max)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .pkt_fwd_cnt  (pkt_fwd_cnt),
        .pkt_drop_cnt (pkt_drop_cnt),
        .err_proto    (err_proto),
        .err_len      (err_len),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctl;    // {valid, sop, eop}
        logic [31:0] data;
        logic [3:0]  full;
        logic        ready;
        logic [3:0]  wr;
        logic [1:0]  flags;  // expected wr_data[33:32]
        logic [2:0]  st;     // {busy, err_proto, err_len} after the edge
        int          fwd;
        int          drop;
    } vec_t;

    vec_t        tbl [23];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cycles      = 0;
    int          act_ep      = 0;
    int          act_el      = 0;
    bit          timeout     = 0;
    logic [33:0] exp_q [4][$];
    logic [33:0] act_q [4][$];

    function automatic int stat(input int v);
`ifdef PORT_INGRESS_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rand_full();
        logic [3:0] f;
        for (int b = 0; b < 4; b++) f[b] = ($urandom_range(0, 3) == 0);
        return f;
    endfunction

    task automatic sample(input bit chk, input bit exp_rdy, input logic [3:0] exp_wr, output bit acc);
        @(negedge clk);
        if (chk) check("rnd in_ready", 34'(bus.in_ready), 34'(exp_rdy));
        check("rnd wr_en", 34'(bus.wr_en), 34'(exp_wr));
        for (int p = 0; p < 4; p++)
            if (bus.wr_en[p]) act_q[p].push_back(bus.wr_data);
        if (err_proto) act_ep++;
        if (err_len)   act_el++;
        acc = bus.in_valid && bus.in_ready;
        cycles++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bit acc;
        bus.in_valid  = 1'b0;
        bus.fifo_full = rand_full();
        sample(1'b0, 1'b1, 4'b0000, acc);
    endtask

    // Hold one word until accepted; wr says whether the model expects it written to port d
    task automatic send_word(input logic sop, input logic eop, input logic [31:0] data,
                             input bit wr, input logic [1:0] d);
        bit acc;
        bit exp_rdy;
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_data  = data;
        acc = 1'b0;
        while (!acc && !timeout) begin
            bus.fifo_full = rand_full();
            exp_rdy = wr ? !bus.fifo_full[d] : 1'b1;
            sample(1'b1, exp_rdy, (wr && exp_rdy) ? (4'b0001 << d) : 4'b0000, acc);
            if (cycles > c_limit) begin
                $display("FAIL rnd timeout: got %0d cycles required below %0d", cycles, c_limit);
                miscompares++;
                timeout = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int          exp_fwd;
        int          exp_drop;
        int          exp_ep;
        int          exp_el;
        int          kind;
        int          len;
        logic        sop;
        logic [31:0] data;
        bit          wr;

        tbl[0]  = '{3'b110, 32'hDEAD_0002, 4'h0, 1'b1, 4'b0100, 2'b10, 3'b100, 0, 0};
        tbl[1]  = '{3'b100, 32'hA000_0001, 4'h0, 1'b1, 4'b0100, 2'b00, 3'b100, 0, 0};
        tbl[2]  = '{3'b100, 32'hA000_0002, 4'h0, 1'b1, 4'b0100, 2'b00, 3'b100, 0, 0};
        tbl[3]  = '{3'b101, 32'hA000_0003, 4'h0, 1'b1, 4'b0100, 2'b01, 3'b000, 1, 0};
        tbl[4]  = '{3'b110, 32'hDEAD_0001, 4'hA, 1'b0, 4'b0000, 2'b00, 3'b000, 1, 0};
        tbl[5]  = '{3'b110, 32'hDEAD_0001, 4'hA, 1'b0, 4'b0000, 2'b00, 3'b000, 1, 0};
        tbl[6]  = '{3'b110, 32'hDEAD_0001, 4'hA, 1'b0, 4'b0000, 2'b00, 3'b000, 1, 0};
        tbl[7]  = '{3'b110, 32'hDEAD_0001, 4'h8, 1'b1, 4'b0010, 2'b10, 3'b100, 1, 0};
        tbl[8]  = '{3'b101, 32'hB000_0001, 4'h8, 1'b1, 4'b0010, 2'b01, 3'b000, 2, 0};
        tbl[9]  = '{3'b000, 32'h0000_0000, 4'h0, 1'b1, 4'b0000, 2'b00, 3'b000, 2, 0};
        tbl[10] = '{3'b110, 32'h1234_5678, 4'h0, 1'b1, 4'b0000, 2'b00, 3'b100, 2, 1};
        tbl[11] = '{3'b100, 32'hC000_0001, 4'hF, 1'b1, 4'b0000, 2'b00, 3'b100, 2, 1};
        tbl[12] = '{3'b101, 32'hC000_0002, 4'hF, 1'b1, 4'b0000, 2'b00, 3'b000, 2, 1};
        tbl[13] = '{3'b110, 32'hDEAD_0000, 4'h0, 1'b1, 4'b0001, 2'b10, 3'b100, 2, 1};
        tbl[14] = '{3'b100, 32'hD000_0001, 4'hE, 1'b1, 4'b0001, 2'b00, 3'b100, 2, 1};
        tbl[15] = '{3'b100, 32'hD000_0002, 4'h0, 1'b1, 4'b0001, 2'b00, 3'b100, 2, 1};
        tbl[16] = '{3'b100, 32'hD000_0003, 4'h0, 1'b1, 4'b0001, 2'b01, 3'b101, 3, 1};
        tbl[17] = '{3'b100, 32'hD000_0004, 4'h1, 1'b1, 4'b0000, 2'b00, 3'b100, 3, 1};
        tbl[18] = '{3'b101, 32'hD000_0005, 4'h0, 1'b1, 4'b0000, 2'b00, 3'b000, 3, 1};
        tbl[19] = '{3'b100, 32'hE000_0000, 4'h0, 1'b1, 4'b0000, 2'b00, 3'b010, 3, 1};
        tbl[20] = '{3'b110, 32'hDEAD_0003, 4'h0, 1'b1, 4'b1000, 2'b10, 3'b100, 3, 1};
        tbl[21] = '{3'b110, 32'hE000_0001, 4'h0, 1'b1, 4'b1000, 2'b00, 3'b110, 3, 1};
        tbl[22] = '{3'b101, 32'hE000_0002, 4'h0, 1'b1, 4'b1000, 2'b01, 3'b000, 4, 1};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.in_data   = 32'h0;
        bus.fifo_full = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("reset busy", 34'(busy), 34'(0));
        check("reset err_proto", 34'(err_proto), 34'(0));
        check("reset err_len", 34'(err_len), 34'(0));
        check("reset fwd", 34'(pkt_fwd_cnt), 34'(0));
        check("reset drop", 34'(pkt_drop_cnt), 34'(0));
        check("reset wr_en", 34'(bus.wr_en), 34'(0));
        @(posedge clk);
        #1;

        for (int r = 0; r < 23; r++) begin
            {bus.in_valid, bus.in_sop, bus.in_eop} = tbl[r].ctl;
            bus.in_data   = tbl[r].data;
            bus.fifo_full = tbl[r].full;
            @(negedge clk);
            check($sformatf("row%0d in_ready", r), 34'(bus.in_ready), 34'(tbl[r].ready));
            check($sformatf("row%0d wr_en", r), 34'(bus.wr_en), 34'(tbl[r].wr));
            check($sformatf("row%0d wr_data", r), bus.wr_data, {tbl[r].flags, tbl[r].data});
            @(posedge clk);
            #1;
            check($sformatf("row%0d busy", r), 34'(busy), 34'(tbl[r].st[2]));
            check($sformatf("row%0d err_proto", r), 34'(err_proto), 34'(tbl[r].st[1]));
            check($sformatf("row%0d err_len", r), 34'(err_len), 34'(tbl[r].st[0]));
            check($sformatf("row%0d fwd", r), 34'(pkt_fwd_cnt), 34'(stat(tbl[r].fwd)));
            check($sformatf("row%0d drop", r), 34'(pkt_drop_cnt), 34'(stat(tbl[r].drop)));
        end

        // Reset after word 2 of a packet, then a single-word packet
        {bus.in_valid, bus.in_sop, bus.in_eop} = 3'b110;
        bus.in_data   = 32'hDEAD_0001;
        bus.fifo_full = 4'h0;
        @(posedge clk);
        #1;
        {bus.in_valid, bus.in_sop, bus.in_eop} = 3'b100;
        bus.in_data = 32'hF000_0001;
        @(posedge clk);
        #1;
        check("mid busy before reset", 34'(busy), 34'(1));
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid reset busy", 34'(busy), 34'(0));
        check("mid reset fwd", 34'(pkt_fwd_cnt), 34'(0));
        check("mid reset drop", 34'(pkt_drop_cnt), 34'(0));
        {bus.in_valid, bus.in_sop, bus.in_eop} = 3'b111;
        bus.in_data = 32'hDEAD_0003;
        @(negedge clk);
        check("single wr_en", 34'(bus.wr_en), 34'(4'b1000));
        check("single wr_data", bus.wr_data, {2'b11, 32'hDEAD_0003});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("single busy", 34'(busy), 34'(0));
        check("single fwd", 34'(pkt_fwd_cnt), 34'(stat(1)));

        // Randomized traffic against the packet-level model
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_fwd  = 0;
        exp_drop = 0;
        exp_ep   = 0;
        exp_el   = 0;
        for (int k = 0; k < c_npkt && !timeout; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                exp_ep++;
                send_word(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0, 2'd0);
            end
            kind = $urandom_range(0, 4);
            len  = $urandom_range(1, 7);
            for (int i = 0; i < len && !timeout; i++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                if (i == 0) begin
                    sop  = 1'b1;
                    data = (kind < 4) ? (32'hDEAD_0000 | 32'(kind))
                                      : (32'h1234_0000 | ($urandom & 32'h0000_FFFF));
                end else begin
                    sop  = ($urandom_range(0, 9) == 0);
                    data = $urandom;
                    if (sop) exp_ep++;
                end
                wr = (kind < 4) && (i < c_max);
                if (wr) exp_q[kind].push_back({(i == 0), (i == len - 1) || (i == c_max - 1), data});
                send_word(sop, (i == len - 1), data, wr, 2'(kind));
            end
            if (kind < 4) begin
                exp_fwd++;
                if (len > c_max) exp_el++;
            end else begin
                exp_drop++;
            end
        end
        repeat (3) idle_cycle();

        for (int p = 0; p < 4; p++) begin
            check($sformatf("rnd port%0d word count", p), 34'(act_q[p].size()), 34'(exp_q[p].size()));
            for (int i = 0; i < exp_q[p].size() && i < act_q[p].size(); i++)
                check($sformatf("rnd port%0d word%0d", p, i), act_q[p][i], exp_q[p][i]);
        end
        check("rnd fwd", 34'(pkt_fwd_cnt), 34'(stat(exp_fwd)));
        check("rnd drop", 34'(pkt_drop_cnt), 34'(stat(exp_drop)));
        check("rnd err_proto pulses", 34'(act_ep), 34'(exp_ep));
        check("rnd err_len pulses", 34'(act_el), 34'(exp_el));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/port_ingress.md
# port_ingress

Ingress packet classifier for the switch's input ports, sitting directly upstream of the per-output-port packet FIFOs. It accepts a framed 32-bit word stream, matches the header word's destination address against four port addresses, and writes the packet into the selected output FIFO as 34-bit words `{sop, eop, data}`. It honours per-FIFO full backpressure, drops unroutable packets, truncates oversize packets and keeps packet statistics.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width; FIFO word width is DATA_WIDTH+2.
- PORT_ADDR0..PORT_ADDR3, 32'hDEAD_0000..32'hDEAD_0003, destination address owned by output port 0..3.
- MAX_WORDS, 64, maximum packet length in words, header included; legal range 2..65535.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready (combinational).
- in_sop  in  1  first word of packet; carries destination address in in_data.
- in_eop  in  1  last word of packet.
- in_data  in  DATA_WIDTH  payload word.
- fifo_full  in  4  full flag of output FIFO p.
- wr_en  out  4  one-hot write strobe to FIFO p (combinational).
- wr_data  out  DATA_WIDTH+2  {sop, eop, in_data}; bit 33 sop, bit 32 eop.
- pkt_fwd_cnt  out  16  packets forwarded, saturating.
- pkt_drop_cnt  out  16  packets dropped, saturating.
- err_proto  out  1  one-cycle pulse on framing error.
- err_len  out  1  one-cycle pulse on truncation.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, FWD, DROP. The block holds registers `cur_port` (2 bits) and `wcnt` (16 bits).
- IDLE, in_sop=1, address match:
  - The port is the lowest p whose PORT_ADDRp equals in_data.
  - in_ready = !fifo_full[p].
  - On accept: wr_en[p]=1, wcnt=1, cur_port=p.
  - With eop: stay IDLE, pkt_fwd_cnt++. Otherwise go to FWD.
- IDLE, in_sop=1, no match:
  - in_ready=1.
  - On accept: pkt_drop_cnt++. With eop, stay IDLE; otherwise go to DROP.
- IDLE, in_sop=0: in_ready=1, word discarded, err_proto pulses.
- FWD:
  - in_ready = !fifo_full[cur_port].
  - On accept: wr_en[cur_port]=1, wcnt++.
  - On eop: go to IDLE, pkt_fwd_cnt++.
  - in_sop=1 in FWD: word written with sop bit cleared, err_proto pulses, packet continues.
- Truncation (FWD):
  - Condition: the accepted word is number MAX_WORDS and in_eop=0.
  - The word is written with the eop bit forced to 1.
  - err_len pulses, pkt_fwd_cnt++, go to DROP.
- DROP:
  - in_ready=1, words discarded, no writes.
  - Accepted eop → IDLE. in_sop in DROP → err_proto, still discarded.
- wr_data = {in_sop_eff, in_eop_eff, in_data} whenever any wr_en bit is set. Otherwise wr_data is don't-care, driven as {2'b0, in_data}.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Zero-cycle write latency: the accept cycle is the FIFO write cycle. fifo_full must be valid in that same cycle.
- in_ready and wr_en are combinational from state, cur_port, in_* and fifo_full. There is no combinational path from wr_en back to fifo_full.
- State, wcnt, counters and err_* update on the clock edge after the accept.
- err_* are registered and assert the cycle after the offending accept, for exactly one cycle.
- A fifo_full on a port other than the target never stalls input.
- Reset values:
  - State IDLE, cur_port 0, wcnt 0, counters 0, err_proto 0, err_len 0, busy 0.
  - wr_en is 0 while in_valid=0.
- Reset mid-packet returns the block to IDLE immediately. The partial packet already in the FIFO is not terminated, and the next input word must carry sop.
- Throughput: one word per cycle while the target FIFO is not full.

## Configuration
- Macro: PORT_INGRESS_STATS_EN.
- Defined: pkt_fwd_cnt and pkt_drop_cnt are implemented as specified.
- Undefined: counter registers are not built and both outputs are tied to 16'h0. err_proto, err_len and all forwarding behaviour are unchanged.

## Test plan
- 4-word packet to 32'hDEAD_0002, all FIFOs empty:
  - wr_en=4'b0100 for 4 consecutive cycles.
  - wr_data[33:32] sequence 10,00,00,01.
  - pkt_fwd_cnt=1, busy low after the eop cycle.
- Header to 32'hDEAD_0001 with fifo_full[1]=1 for 3 cycles, fifo_full[3]=1 throughout:
  - in_ready=0 and wr_en=0 for 3 cycles.
  - Header written in cycle 4. Port 3 full has no effect.
- Header 32'h1234_5678, 3 words: all accepted, wr_en stays 0, pkt_drop_cnt=1.
- MAX_WORDS=4, 6-word packet to port 0:
  - 4 writes, the 4th with wr_data[32]=1.
  - err_len pulses once, words 5-6 discarded, pkt_fwd_cnt=1.
- Framing errors:
  - Non-sop word in IDLE: err_proto pulse, no write.
  - sop mid-packet in FWD: written with bit 33=0, err_proto pulse.
- Reset mid-packet:
  - Reset asserted after word 2 of a 5-word packet: next cycle busy=0 and counters 0.
  - A subsequent single-word sop+eop packet to 32'hDEAD_0003 gives one write with wr_data[33:32]=11.
